// File: rtl/cn_pkg.sv
// Shared types and constants for the change/no-change (CN) bank arbiter.
package cn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } cn_state_e;

  localparam logic CN_HOLD = 1'b0;
  localparam logic CN_LOAD = 1'b1;

  localparam int CN_NREQ_DEF  = 4;
  localparam int CN_WIDTH_DEF = 8;

endpackage

// File: rtl/cn_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module cn_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  logic found;
  int   j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cn_bank_arbiter.sv
// Round-robin write arbiter in front of a CN flop bank held in this block.
// Optional per-bit write lock enabled by defining CN_LOCK_EN.
//
// state | meaning
// IDLE  | nothing registered, c_vec/n_vec/gnt all zero
// GRANT | one winner's write registered on c_vec/n_vec, gnt pulsed
// CLEAR | bulk clear registered (c_vec all ones, n_vec zero), no grant
module cn_bank_arbiter
  import cn_pkg::*;
#(
  parameter  int NREQ  = CN_NREQ_DEF,
  parameter  int WIDTH = CN_WIDTH_DEF,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ-1:0]      req_val,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     c_vec,
  output logic [WIDTH-1:0]     n_vec,
  output logic [WIDTH-1:0]     q_vec,
  output logic                 busy
`ifdef CN_LOCK_EN
  ,
  input  logic [WIDTH-1:0]     lock_vec,
  output logic                 lock_err
`endif
);

  localparam int PW = $clog2(NREQ);

  cn_state_e        state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  win;
  logic [PW-1:0]    win_idx;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_val;
  logic             sel_lock;
  logic [WIDTH-1:0] lock_mask;
  logic [NREQ-1:0]  gnt_d;
  logic [WIDTH-1:0] c_d, n_d;
  logic             any_req;

  cn_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

`ifdef CN_LOCK_EN
  assign lock_mask = lock_vec;
`else
  assign lock_mask = '0;
`endif

  assign any_req  = |req;
  assign sel_idx  = req_idx[int'(win_idx)*IDXW +: IDXW];
  assign sel_val  = req_val[win_idx];
  assign sel_lock = lock_mask[sel_idx];
  assign busy     = any_req | (|c_vec);

  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    c_d     = '0;
    n_d     = '0;
    case (state_q)
      IDLE, GRANT, CLEAR: begin
        if (clr) begin
          // clear outranks every request; pending requesters simply wait
          state_d = CLEAR;
          c_d     = {WIDTH{CN_LOAD}} & ~lock_mask;
        end else if (any_req) begin
          state_d      = GRANT;
          gnt_d        = win;
          c_d[sel_idx] = sel_lock ? CN_HOLD : CN_LOAD;
          n_d[sel_idx] = sel_val;
          ptr_d        = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
      end
      // an illegal encoding drops back to IDLE without issuing a write
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      c_vec   <= '0;
      n_vec   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      c_vec   <= c_d;
      n_vec   <= n_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vec <= '0;
    end else begin
      q_vec <= (q_vec & ~c_vec) | (n_vec & c_vec);
    end
  end

`ifdef CN_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_err <= 1'b0;
    end else begin
      lock_err <= !clr && any_req && sel_lock;
    end
  end
`endif

endmodule

// File: tb/tb_cn_bank_arbiter.sv
// Scoreboard bench for cn_bank_arbiter: stimulus pushes expected gnt/c/n,
// a negedge monitor pops and compares whenever the DUT drives a write.
module tb_cn_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_idx;
  logic [3:0]  req_val;
  logic        clr;
  logic [3:0]  gnt;
  logic [7:0]  c_vec, n_vec, q_vec;
  logic        busy;
`ifdef CN_LOCK_EN
  logic [7:0]  lock_vec;
  logic        lock_err;
`endif

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] c;
    logic [7:0] n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  cn_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_idx (req_idx),
    .req_val (req_val),
    .clr     (clr),
    .gnt     (gnt),
    .c_vec   (c_vec),
    .n_vec   (n_vec),
    .q_vec   (q_vec),
    .busy    (busy)
`ifdef CN_LOCK_EN
    ,
    .lock_vec(lock_vec),
    .lock_err(lock_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] c, input logic [7:0] n);
    exp_t e;
    e.g = g;
    e.c = c;
    e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [2:0] idx, input logic val);
    req_idx[i*3 +: 3] = idx;
    req_val[i]        = val;
  endtask

  task automatic do_reset();
    req     = '0;
    req_idx = '0;
    req_val = '0;
    clr     = 1'b0;
`ifdef CN_LOCK_EN
    lock_vec = '0;
`endif
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // monitor: every cycle with a visible write or grant consumes one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (gnt != 4'b0 || c_vec != 8'b0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual gnt=%b c=%h n=%h required none t=%0t",
                   gnt, c_vec, n_vec, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_gnt", 32'(gnt), 32'(e.g));
          chk("mon_c_vec", 32'(c_vec), 32'(e.c));
          chk("mon_n_vec", 32'(n_vec), 32'(e.n));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    do_reset();
    chk("rst_q_vec", 32'(q_vec), 32'h0);
    chk("rst_c_vec", 32'(c_vec), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // single write: req0 bit 3 <= 1
    set_req(0, 3'd3, 1'b1);
    req = 4'b0001;
    push(4'b0001, 8'h08, 8'h08);
    step();
    chk("single_busy_hi", 32'(busy), 32'h1);
    req = 4'b0000;
    step();
    chk("single_q_vec", 32'(q_vec), 32'h08);
    chk("single_busy_lo", 32'(busy), 32'h0);

    // round robin from p=0 with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 1'b1);
    req = 4'b1111;
    push(4'b0001, 8'h01, 8'h01);
    push(4'b0010, 8'h02, 8'h02);
    push(4'b0100, 8'h04, 8'h04);
    push(4'b1000, 8'h08, 8'h08);
    push(4'b0001, 8'h01, 8'h01);
    for (int i = 0; i < 5; i++) step();
    req = 4'b0000;
    step();
    chk("rr_q_vec", 32'(q_vec), 32'h0F);

    // same-index conflict: later grant wins
    do_reset();
    set_req(0, 3'd2, 1'b1);
    set_req(1, 3'd2, 1'b0);
    req = 4'b0011;
    push(4'b0001, 8'h04, 8'h04);
    push(4'b0010, 8'h04, 8'h00);
    step();
    req = 4'b0010;
    step();
    chk("conflict_q_mid", 32'(q_vec), 32'h04);
    req = 4'b0000;
    step();
    chk("conflict_q_end", 32'(q_vec), 32'h00);

    // fill bank, then clr against a simultaneous request
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 3'(i), 1'b1);
      push(4'b0001, 8'(1 << i), 8'(1 << i));
      step();
    end
    chk("fill_q_vec", 32'(q_vec), 32'h7F);
    req = 4'b0010;
    set_req(1, 3'd5, 1'b1);
    clr = 1'b1;
    push(4'b0000, 8'hFF, 8'h00);
    step();
    chk("clr_gnt", 32'(gnt), 32'h0);
    chk("clr_c_vec", 32'(c_vec), 32'hFF);
    chk("clr_n_vec", 32'(n_vec), 32'h00);
    chk("clr_q_full", 32'(q_vec), 32'hFF);
    clr = 1'b0;
    push(4'b0010, 8'h20, 8'h20);
    step();
    chk("clr_q_cleared", 32'(q_vec), 32'h00);
    chk("clr_then_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("clr_after_q", 32'(q_vec), 32'h20);

    // reset asserted with a write in flight
    set_req(0, 3'd0, 1'b1);
    req = 4'b0001;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q_vec", 32'(q_vec), 32'h0);
    chk("midrst_c_vec", 32'(c_vec), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_q_hold", 32'(q_vec), 32'h0);

`ifdef CN_LOCK_EN
    lock_vec = 8'h01;
    set_req(0, 3'd0, 1'b1);
    req = 4'b0001;
    push(4'b0001, 8'h00, 8'h01);
    step();
    chk("lock_err_hi", 32'(lock_err), 32'h1);
    req = 4'b0000;
    step();
    chk("lock_err_lo", 32'(lock_err), 32'h0);
    chk("lock_q_vec", 32'(q_vec), 32'h0);
    lock_vec = 8'h00;
    req = 4'b0001;
    push(4'b0001, 8'h01, 8'h01);
    step();
    req = 4'b0000;
    step();
    chk("lock_write_q", 32'(q_vec), 32'h01);
    lock_vec = 8'h01;
    clr = 1'b1;
    push(4'b0000, 8'hFE, 8'h00);
    step();
    clr = 1'b0;
    step();
    chk("lock_clr_q", 32'(q_vec), 32'h01);
`endif

    step();
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cn_bank_arbiter.md
Name: cn_bank_arbiter

Overview:
- Shares a bank of WIDTH change/no-change (CN) state bits among NREQ requesters.
- Each requester asks to write one bit (index, value). A round-robin arbiter grants at most one write per cycle and drives the bank's c/n control vectors.
- CN cell rule: c=0 keeps q; c=1 loads q<=n.
- Sits between control masters and the CN flop bank. The bank is held inside this block; its state is exported as q_vec.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, number of CN bits in the bank (power of 2, 2..32)
IDXW, $clog2(WIDTH), localparam, bit-index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request, level, held until granted
req_idx  input  NREQ*IDXW  packed bit index per requester (requester i at [i*IDXW +: IDXW])
req_val  input  NREQ  value to write per requester
clr  input  1  bulk clear of whole bank (all c=1, n=0)
gnt  output  NREQ  one-hot grant pulse, registered, one cycle
c_vec  output  WIDTH  registered change-enable vector applied to the bank
n_vec  output  WIDTH  registered next-value vector applied to the bank
q_vec  output  WIDTH  bank state
busy  output  1  high when any req bit is high or a write is in flight

Behaviour:
- Reset (rst_n=0, async): gnt=0, c_vec=0, n_vec=0, q_vec=0, busy=0, rr pointer=0, state=IDLE.
- Pipeline:
  - Edge k: arbiter samples req/clr; registers gnt, c_vec, n_vec.
  - Edge k+1: bank applies q[i] <= c_vec[i] ? n_vec[i] : q[i] for every i.
  - Write latency from sampled request to q_vec change is 2 cycles.
- FSM states:
  - IDLE: no request. c_vec=0, n_vec=0, gnt=0. Goes to GRANT on any req bit, or to CLEAR on clr.
  - GRANT: one winner per cycle. Stays while requests remain. Goes to IDLE when req=0. Goes to CLEAR on clr.
  - CLEAR: one cycle with c_vec=all 1s, n_vec=0, gnt=0. Returns to GRANT if any req bit, else IDLE.
- Arbitration:
  - Winner is the first set req bit searching upward from pointer p, wrapping NREQ-1 -> 0.
  - After a grant, p <= winner+1 mod NREQ. p is unchanged when there is no grant.
  - For winner w with index x: gnt[w]=1; c_vec has only bit x set; n_vec[x]=req_val[w]; all other n_vec bits are 0.
- Handshake:
  - A requester sees gnt[w] high for one cycle. It must drop req or present the next request in the cycle after.
  - req still high in the cycle after gnt counts as a new request.
  - Changing req_idx/req_val while req is high and ungranted is allowed; the value sampled at the granting edge is used.
- clr:
  - Has priority over all requests in the same cycle. No grant is issued that cycle and pending requests wait.
  - clr held for multiple cycles repeats CLEAR and starves grants.
- Same-index conflicts: serialised by arbitration. The later grant wins in q_vec.
- busy = |req | (c_vec != 0), combinational from registered c_vec.
- Index out of range cannot occur because WIDTH is a power of 2.
- Reset asserted mid-operation: all registers clear immediately. An in-flight c_vec is discarded and q_vec=0.

Optional Feature:
CN_LOCK_EN
- Defined:
  - Adds input lock_vec[WIDTH] and output lock_err (1 bit, registered).
  - A grant targeting a locked bit is still issued, so the requester is released. Its c_vec bit is forced to 0 and lock_err pulses for 1 cycle, aligned with gnt.
  - clr also skips locked bits: c_vec = ~lock_vec.
  - lock_err resets to 0.
- Undefined: ports absent; all grants and clears write unconditionally.

Decomposition:
- Shared package cn_pkg:
  - state enum {IDLE, GRANT, CLEAR}
  - constants CN_HOLD (c=0) and CN_LOAD (c=1)
  - default NREQ/WIDTH
- One sub-module: cn_rr_pick, a combinational round-robin priority picker. Inputs req and pointer; outputs one-hot winner and winner index.
- The bank is a simple always-block vector in the top module.

Test Plan:
- Reset: rst_n=0 mid-run with q_vec=8'hA5 -> q_vec, c_vec, gnt all 0 immediately; p=0.
- Single write: req=4'b0001, idx0=3, val0=1 -> gnt=0001 after 1 edge, c_vec=8'h08, n_vec=8'h08; q_vec=8'h08 after 2 edges.
- Round-robin: req=4'b1111 held, distinct idx 0..3, val=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; q_vec reaches 8'h0F.
- Conflict: req0 idx2 val1 and req1 idx2 val0 asserted together from p=0 -> req0 granted first, then req1; final q_vec[2]=0.
- clr priority: q_vec=8'hFF, clr=1 with req=0010 in the same cycle -> no grant that cycle, c_vec=8'hFF, n_vec=0; q_vec=0 one edge later; req1 granted the next cycle.
- CN_LOCK_EN: lock_vec=8'h01, req0 idx0 val1 -> gnt[0]=1, lock_err=1, c_vec=0, q_vec[0] unchanged; clr leaves bit 0 set.
